// File: rtl/glitch_mon_pkg.sv
// glitch_mon_pkg: shared FSM encoding and frame constants for the glitch monitor framer
package glitch_mon_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, LATCH, SEND, WAIT_ACK, WAIT_IDLE, GAP} state_t;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int CNT_W = 8;
endpackage

// File: rtl/glitch_ch_counter.sv
// glitch_ch_counter: per-channel sticky alarm flag plus saturating hit counter
// Ports: clk, reset (async, active-high), clr (zero flag and count), en (count one hit),
//        flag (sticky, set by any hit), count (hits, saturates at all-ones)
module glitch_ch_counter
  import glitch_mon_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic             flag,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      flag  <= 1'b0;
      count <= '0;
    end else if (clr) begin
      flag  <= 1'b0;
      count <= '0;
    end else if (en) begin
      flag  <= 1'b1;
      count <= (&count) ? count : count + 1'b1;
    end
endmodule

// File: rtl/glitch_monitor_framer.sv
// glitch_monitor_framer: counts masked alarms in an armed window, then sends a checksummed frame over a UART
// Ports: clk, reset (async, active-high); alarm_in/ch_mask per channel; arm/disarm/payload_valid window control;
//        payload_in result data (byte 0 = MSB); tx_start/tx_data/tx_busy UART handshake;
//        armed, frame_busy, any_alarm status
module glitch_monitor_framer
  import glitch_mon_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int PAYLOAD_BYTES = 16,
  parameter int GAP_CYCLES    = 20000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          alarm_in,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic [8*PAYLOAD_BYTES-1:0] payload_in,
  input  logic                       payload_valid,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic                       armed,
  output logic                       frame_busy,
  output logic                       any_alarm
);
  localparam int FL       = NUM_CH + PAYLOAD_BYTES + 3;
  localparam int IW       = $clog2(FL);
  localparam int PW       = 8 * PAYLOAD_BYTES;
  localparam int SW       = (NUM_CH + PAYLOAD_BYTES + 2) * 8;
  localparam int GW       = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  localparam logic [IW-1:0] LAST = IW'(FL - 1);

  state_t                   state, next;
  logic [NUM_CH-1:0]        flags, hit;
  logic [NUM_CH*CNT_W-1:0]  cnt_bytes;
  logic [SW-1:0]            sr;
  logic [7:0]               csum, cur_byte;
  logic [IW-1:0]            idx;
  logic [GW-1:0]            gap_cnt;
  logic [1:0]               ack_cnt;
  logic                     clr;

  assign clr       = (state == IDLE) && arm;
  assign hit       = alarm_in & ch_mask & {NUM_CH{state == ARMED}};
  assign any_alarm = |flags;
  // the byte after idx is the checksum once idx reaches the last data byte
  assign cur_byte  = (idx == LAST - 1'b1) ? csum : sr[SW-1 -: 8];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    glitch_ch_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (hit[i]),
      .flag  (flags[i]),
      .count (cnt_bytes[(NUM_CH-1-i)*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next;

  always_comb begin
    next       = state;
    armed      = state == ARMED;
    frame_busy = !(state == IDLE || state == ARMED);
    tx_start   = state == SEND;
    case (state)
      IDLE:      next = arm ? ARMED : IDLE;
      ARMED:     next = payload_valid ? LATCH : (disarm ? IDLE : ARMED);
      LATCH:     next = SEND;
      SEND:      next = WAIT_ACK;
      WAIT_ACK:  next = (tx_busy || ack_cnt == 2'd3) ? WAIT_IDLE : WAIT_ACK;
      WAIT_IDLE: next = tx_busy ? WAIT_IDLE : (idx == LAST) ? IDLE : (GAP_CYCLES == 0) ? SEND : GAP;
      GAP:       next = (gap_cnt == GW'(GAP_LAST)) ? SEND : GAP;
      default:   next = IDLE;
    endcase
  end

  // Payload lands in the low bits when the window closes; LATCH fills the rest.
  // The header goes straight to tx_data, so the snapshot is loaded already shifted past it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr      <= '0;
      csum    <= '0;
      idx     <= '0;
      tx_data <= '0;
      gap_cnt <= '0;
      ack_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 1'b1 : '0;
      if (state == ARMED && payload_valid) sr[PW-1:0] <= payload_in;
      if (state == LATCH) begin
        sr      <= {8'(flags), cnt_bytes, sr[PW-1:0], 8'h00};
        tx_data <= HEADER_BYTE;
        csum    <= HEADER_BYTE;
        idx     <= '0;
      end else if (next == SEND) begin
        tx_data <= cur_byte;
        csum    <= csum ^ cur_byte;
        sr      <= sr << 8;
        idx     <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_glitch_monitor_framer.sv
// tb_glitch_monitor_framer: directed and randomized frame checks against a behavioural frame model
module tb_glitch_monitor_framer;
  localparam int NCH = 4, PB = 2, GAP = 3, FL = NCH + PB + 3;

  logic clk = 0, reset = 1;
  logic [3:0] alarm_in = 0, ch_mask = 0;
  logic arm = 0, disarm = 0, payload_valid = 0, tx_busy = 0;
  logic [15:0] payload_in = 0;
  logic tx_start, armed, frame_busy, any_alarm;
  logic [7:0] tx_data;

  int tests = 0, fails = 0;
  logic [7:0] q[$];
  logic [3:0] seq[$];
  bit hold_busy = 0;
  logic [3:0] mflags;
  int mcnt[NCH];
  int u_n = 0, u_drop = 0, u_cyc = 0;
  bit u_gap_ok = 0;

  glitch_monitor_framer #(.NUM_CH(NCH), .PAYLOAD_BYTES(PB), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .ch_mask(ch_mask), .arm(arm),
    .disarm(disarm), .payload_in(payload_in), .payload_valid(payload_valid),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .armed(armed),
    .frame_busy(frame_busy), .any_alarm(any_alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qb(input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  task automatic model_hit(input logic [3:0] a);
    for (int i = 0; i < NCH; i++)
      if (a[i] && ch_mask[i]) begin
        mflags[i] = 1'b1;
        if (mcnt[i] < 255) mcnt[i]++;
      end
  endtask

  // UART stand-in: records every started byte, stays busy a random while,
  // and checks the idle gap between busy falling and the next byte of the frame
  initial begin
    forever begin
      @(negedge clk);
      u_cyc++;
      if (reset) begin
        u_n = 0;
        u_gap_ok = 0;
      end else begin
        if (!frame_busy) u_gap_ok = 0;
        if (tx_start) begin
          if (u_gap_ok) chk("gap", u_cyc - u_drop, GAP + 1);
          u_gap_ok = 0;
          q.push_back(tx_data);
          u_n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 6));
        end else if (u_n > 0) begin
          u_n--;
          if (u_n == 0) begin
            u_drop = u_cyc;
            u_gap_ok = 1;
          end
        end
      end
      tx_busy = hold_busy || u_n > 0;
    end
  end

  task automatic do_window(input string nm, input logic [3:0] mask, input logic [15:0] pl, input bit dis);
    logic [7:0] exp[FL];
    logic [7:0] x;
    bit done;
    q.delete();
    mflags = 0;
    foreach (mcnt[i]) mcnt[i] = 0;
    @(negedge clk);
    arm = 1;
    ch_mask = mask;
    @(negedge clk);
    arm = 0;
    chk({nm, "_armed"}, armed, 1);
    for (int k = 0; k < seq.size(); k++) begin
      alarm_in = seq[k];
      if (k == seq.size() - 1) begin
        payload_valid = 1;
        payload_in = pl;
        disarm = dis;
      end
      @(negedge clk);
      model_hit(seq[k]);
      chk({nm, "_any"}, any_alarm, mflags != 0);
    end
    payload_valid = 0;
    disarm = 0;
    alarm_in = 0;
    chk({nm, "_fbusy"}, frame_busy, 1);
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (!frame_busy) done = 1;
      else begin
        alarm_in = 4'($urandom);
        arm = $urandom_range(0, 7) == 0;
        disarm = $urandom_range(0, 7) == 0;
        payload_valid = $urandom_range(0, 7) == 0;
      end
    end
    alarm_in = 0;
    arm = 0;
    disarm = 0;
    payload_valid = 0;
    chk({nm, "_done"}, done, 1);
    exp[0] = 8'hA5;
    exp[1] = {4'b0, mflags};
    for (int i = 0; i < NCH; i++) exp[2 + i] = 8'(mcnt[i]);
    exp[2 + NCH] = pl[15:8];
    exp[3 + NCH] = pl[7:0];
    x = 0;
    for (int i = 0; i < FL - 1; i++) x ^= exp[i];
    exp[FL - 1] = x;
    chk({nm, "_len"}, q.size(), FL);
    for (int i = 0; i < FL; i++) chk($sformatf("%s_b%0d", nm, i), qb(i), exp[i]);
    chk({nm, "_any_after"}, any_alarm, mflags != 0);
  endtask

  initial begin
    bit hit3;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_armed", armed, 0);
    chk("rst_frame_busy", frame_busy, 0);
    chk("rst_any_alarm", any_alarm, 0);
    reset = 0;

    seq = '{4'h0, 4'h0, 4'h0};
    do_window("plain", 4'hF, 16'h1234, 0);
    chk("plain_csum_const", qb(8), 8'h83);

    seq = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0};
    do_window("ch13", 4'hF, 16'hBEEF, 0);
    chk("ch13_flag", qb(1), 8'h0A);
    chk("ch13_c1", qb(3), 8'h02);
    chk("ch13_c3", qb(5), 8'h01);

    seq.delete();
    repeat (300) begin
      seq.push_back(4'h1);
      seq.push_back(4'h0);
    end
    do_window("sat", 4'hF, 16'h0F0F, 0);
    chk("sat_c0", qb(2), 8'hFF);

    seq = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h4};
    do_window("mask", 4'hE, 16'h5A5A, 0);
    chk("mask_flag", qb(1), 8'h04);
    chk("mask_c0", qb(2), 8'h00);
    chk("mask_c2", qb(4), 8'h01);

    seq = '{4'h3, 4'h0};
    do_window("dis_pv", 4'hF, 16'hC001, 1);

    q.delete();
    @(negedge clk);
    arm = 1;
    ch_mask = 4'hF;
    @(negedge clk);
    arm = 0;
    alarm_in = 4'h4;
    @(negedge clk);
    alarm_in = 0;
    disarm = 1;
    @(negedge clk);
    disarm = 0;
    chk("dis_armed", armed, 0);
    repeat (40) @(negedge clk);
    chk("dis_no_tx", q.size(), 0);
    chk("dis_fbusy", frame_busy, 0);
    chk("dis_flags_hold", any_alarm, 1);

    for (int r = 0; r < 6; r++) begin
      seq.delete();
      repeat ($urandom_range(3, 25)) seq.push_back(($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
      do_window($sformatf("rnd%0d", r), 4'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
    end

    seq = '{4'h1, 4'h2, 4'h0};
    q.delete();
    mflags = 0;
    @(negedge clk);
    arm = 1;
    ch_mask = 4'hF;
    @(negedge clk);
    arm = 0;
    foreach (seq[k]) begin
      alarm_in = seq[k];
      payload_valid = k == seq.size() - 1;
      payload_in = 16'hABCD;
      @(negedge clk);
    end
    alarm_in = 0;
    payload_valid = 0;
    hit3 = 0;
    for (int c = 0; c < 2000 && !hit3; c++) begin
      @(negedge clk);
      hit3 = q.size() >= 3;
    end
    chk("rst_mid_reach", hit3, 1);
    hold_busy = 1;
    repeat (10) @(negedge clk);
    chk("rst_mid_stuck", q.size(), 3);
    chk("rst_mid_fbusy", frame_busy, 1);
    #1 reset = 1;
    #1;
    chk("rst_mid_tx_start", tx_start, 0);
    chk("rst_mid_tx_data", tx_data, 8'h00);
    chk("rst_mid_armed", armed, 0);
    chk("rst_mid_fbusy0", frame_busy, 0);
    chk("rst_mid_any", any_alarm, 0);
    @(negedge clk);
    reset = 0;
    repeat (30) begin
      @(negedge clk);
      alarm_in = 4'($urandom);
    end
    hold_busy = 0;
    alarm_in = 0;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_tx", q.size(), 3);
    chk("rst_mid_any_idle", any_alarm, 0);

    seq = '{4'h8, 4'h8, 4'h1};
    do_window("recover", 4'hF, 16'h0001, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/glitch_monitor_framer.md
GLITCH_MONITOR_FRAMER -- requirements
Module: glitch_monitor_framer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of glitch-detector alarm channels (legal 1..8).
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 16, payload bytes per frame (legal 1..32).
REQ-003 SHALL have parameter GAP_CYCLES, default 20000, idle clk cycles between transmitted bytes (0 legal = no gap).
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port alarm_in  in  NUM_CH  detector alarms, synchronous to clk; single-cycle pulses are legal.
REQ-007 SHALL have port ch_mask  in  NUM_CH  per-channel enable; 1 = channel counted.
REQ-008 SHALL have port arm  in  1  one-cycle pulse that opens a detection window.
REQ-009 SHALL have port disarm  in  1  one-cycle pulse that aborts the window with no frame sent.
REQ-010 SHALL have port payload_in  in  8*PAYLOAD_BYTES  result data (e.g. AES output); byte 0 = MSB byte.
REQ-011 SHALL have port payload_valid  in  1  one-cycle pulse that closes the window and captures payload_in.
REQ-012 SHALL have port tx_start  out  1  one-cycle pulse to the UART transmitter.
REQ-013 SHALL have port tx_data  out  8  byte to transmit, stable from tx_start until the next tx_start.
REQ-014 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-015 SHALL have port armed  out  1  high while the window is open.
REQ-016 SHALL have port frame_busy  out  1  high from window close until the last byte completes.
REQ-017 SHALL have port any_alarm  out  1  OR of the sticky flags, live.

Function
REQ-018 States: IDLE, ARMED, LATCH, SEND, WAIT_ACK, WAIT_IDLE, GAP.
REQ-019 IDLE + arm: clear flags/counters; next cycle ARMED; arm in any other state is ignored.
REQ-020 In ARMED, each cycle, for every channel with alarm_in & ch_mask set: set sticky flag; increment 8-bit counter, saturating at 255.
REQ-021 ARMED + disarm: go IDLE; no frame; flags/counters hold until the next arm.
REQ-022 ARMED + payload_valid: capture payload_in; go LATCH; alarms in that same cycle are counted.
REQ-023 payload_valid and disarm in the same cycle: payload_valid wins.
REQ-024 LATCH: snapshot the frame; alarms after LATCH are not counted; go SEND.
REQ-025 Frame order: 0xA5 header; flag byte (bit i = channel i, unused bits 0); NUM_CH counter bytes, channel 0 first; PAYLOAD_BYTES payload bytes; checksum byte.
REQ-026 Checksum = XOR of every preceding frame byte, header included.
REQ-027 Frame length = NUM_CH + PAYLOAD_BYTES + 3 bytes; byte index counter width = clog2 of that length.
REQ-028 SEND: drive tx_data, pulse tx_start one cycle; go WAIT_ACK.
REQ-029 WAIT_ACK: wait one cycle minimum, then wait until tx_busy = 1 or 4 cycles elapse; go WAIT_IDLE.
REQ-030 WAIT_IDLE: wait for tx_busy = 0; on the last byte go IDLE, else go GAP.
REQ-031 GAP: count GAP_CYCLES cycles, then SEND; GAP_CYCLES = 0 goes straight to SEND.
REQ-032 armed = (state == ARMED); frame_busy = state in {LATCH, SEND, WAIT_ACK, WAIT_IDLE, GAP}.

Reset
REQ-033 Reset SHALL act asynchronously and force: state IDLE; tx_start 0; tx_data 0x00; armed 0; frame_busy 0; any_alarm 0; flags, counters, byte index and gap counter 0.
REQ-034 Reset mid-frame SHALL abort transmission immediately; no partial tx_start pulse after reset deasserts.

Structure
REQ-035 Shared package glitch_mon_pkg SHALL hold: state encoding, HEADER_BYTE = 0xA5, counter width 8.
REQ-036 Sub-module glitch_ch_counter (one per channel, via generate) SHALL implement the sticky flag plus saturating counter with clear and enable.
REQ-037 The frame snapshot SHALL be one shift register of (NUM_CH+PAYLOAD_BYTES+2)*8 bits; the checksum SHALL be accumulated while shifting.

Verification
REQ-038 Setup NUM_CH=4, PAYLOAD_BYTES=2, GAP_CYCLES=3, mask 0xF; arm, no alarms, payload 0x1234 -> bytes A5 00 00 00 00 00 12 34 A5^12^34=83.
REQ-039 Two pulses on ch1 and one on ch3 -> flag 0x0A, counters 00 02 00 01, any_alarm = 1 after the first pulse.
REQ-040 300 alarm pulses on ch0 -> counter byte FF, no wrap to 00.
REQ-041 ch_mask = 0xE with an alarm on ch0 -> flag 0x00; alarm on ch2 in the same cycle as payload_valid -> counted.
REQ-042 disarm and payload_valid in the same cycle -> frame sent; disarm alone -> no tx_start, returns to IDLE.
REQ-043 Reset during byte 3 with tx_busy held -> outputs at reset values; tx_start stays 0 until the next arm/payload_valid.
